// File: rtl/serial_y_pkg.sv
// Shared definitions for the y serial line: state encoding and default word width.
// Used by serial_y_tx and by the matching receiver.
package serial_y_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shift register.
// sout always shows the bit that leaves next.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      q <= '0;
    end else if (load) begin
      q <= data_in;
    end else if (shift_en) begin
      if (MSB_FIRST)
        q <= {q[WIDTH-2:0], 1'b0};
      else
        q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign sout = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/serial_y_tx.sv
// Transmitter for the y serial line: start, WIDTH data bits, stop.
// Define SERIAL_Y_TX_PARITY_EN to add an even-parity bit after the data.
module serial_y_tx
  import serial_y_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             y,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            y_d;
  logic            sout;
  logic            shift_en;
  logic            accept;

  assign ready  = (state == ST_IDLE) || (state == ST_STOP);
  assign accept = load && ready;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_STOP);

`ifdef SERIAL_Y_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge CLK) begin
    if (!RST)
      par_q <= 1'b0;
    else if (accept)
      par_q <= ^data_in;
  end
`endif

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift_en (shift_en),
    .data_in  (data_in),
    .sout     (sout)
  );

  // y is registered, so y_d is the level for the state being entered
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    y_d      = IDLE_LEVEL;
    shift_en = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          cnt_d   = CW'(WIDTH - 1);
          y_d     = ~IDLE_LEVEL;
        end
      end
      ST_START: begin
        state_d  = ST_DATA;
        y_d      = sout;
        shift_en = 1'b1;
      end
      ST_DATA: begin
        if (cnt == '0) begin
`ifdef SERIAL_Y_TX_PARITY_EN
          state_d = ST_PAR;
          y_d     = par_q;
`else
          state_d = ST_STOP;
          y_d     = IDLE_LEVEL;
`endif
        end else begin
          cnt_d    = cnt - 1'b1;
          y_d      = sout;
          shift_en = 1'b1;
        end
      end
`ifdef SERIAL_Y_TX_PARITY_EN
      ST_PAR: begin
        state_d = ST_STOP;
        y_d     = IDLE_LEVEL;
      end
`endif
      ST_STOP: begin
        if (accept) begin
          state_d = ST_START;
          cnt_d   = CW'(WIDTH - 1);
          y_d     = ~IDLE_LEVEL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        y_d     = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      y     <= IDLE_LEVEL;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      y     <= y_d;
    end
  end

endmodule

// File: tb/tb_serial_y_tx.sv
// Bench for serial_y_tx: MSB-first and LSB-first instances share stimulus.
// Expected per-cycle line levels are queued on accept and popped by a monitor.
module tb_serial_y_tx;

  localparam int W   = 8;
  localparam bit IDL = 1'b0;
`ifdef SERIAL_Y_TX_PARITY_EN
  localparam int FL = W + 3;
`else
  localparam int FL = W + 2;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data_in = '0;

  logic rdy_m, y_m, busy_m, done_m;
  logic rdy_l, y_l, busy_l, done_l;

  typedef struct packed {
    logic ym;
    logic yl;
    logic dn;
  } item_t;

  item_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    remain = 0;
  bit    mon_on = 1'b0;

  always #5 CLK = ~CLK;

  serial_y_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDL)) u_msb (
    .CLK     (CLK),
    .RST     (RST),
    .data_in (data_in),
    .load    (load),
    .ready   (rdy_m),
    .y       (y_m),
    .busy    (busy_m),
    .done    (done_m)
  );

  serial_y_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDL)) u_lsb (
    .CLK     (CLK),
    .RST     (RST),
    .data_in (data_in),
    .load    (load),
    .ready   (rdy_l),
    .y       (y_l),
    .busy    (busy_l),
    .done    (done_l)
  );

  // A frame as the line should show it, one entry per cycle
  task automatic push_frame(input logic [W-1:0] d);
    item_t it;
    it = '{ym: ~IDL, yl: ~IDL, dn: 1'b0};
    exp_q.push_back(it);
    for (int i = 0; i < W; i++) begin
      it = '{ym: d[W-1-i], yl: d[i], dn: 1'b0};
      exp_q.push_back(it);
    end
`ifdef SERIAL_Y_TX_PARITY_EN
    it = '{ym: ^d, yl: ^d, dn: 1'b0};
    exp_q.push_back(it);
`endif
    it = '{ym: IDL, yl: IDL, dn: 1'b1};
    exp_q.push_back(it);
  endtask

  // One clock: drive, check ready, advance the model at the edge
  task automatic step(input logic r, input logic l, input logic [W-1:0] d);
    logic rexp;
    RST     = r;
    load    = l;
    data_in = d;
    rexp    = (remain <= 1);
    checks++;
    if (rdy_m !== rexp || rdy_l !== rexp) begin
      errors++;
      $display("FAIL ready: got %b/%b want %b at %0t",
               rdy_m, rdy_l, rexp, $time);
    end
    @(posedge CLK);
    if (!r) begin
      exp_q.delete();
      remain = 0;
    end else if (l && rexp) begin
      push_frame(d);
      remain = FL;
    end else if (remain > 0) begin
      remain--;
    end
    #2;
  endtask

  always @(negedge CLK) begin : mon
    item_t      e;
    logic [5:0] got;
    logic [5:0] want;
    if (mon_on) begin
      got = {y_m, y_l, busy_m, busy_l, done_m, done_l};
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        want = {e.ym, e.yl, 2'b11, e.dn, e.dn};
      end else begin
        want = {IDL, IDL, 4'b0000};
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL line y_m,y_l,busy2,done2: got %b want %b at %0t",
                 got, want, $time);
      end
    end
  end

  initial begin
    logic         r;
    logic         l;
    logic [W-1:0] d;

    RST     = 1'b0;
    load    = 1'b1;
    data_in = 8'hFF;
    @(posedge CLK);
    #2;
    mon_on = 1'b1;
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    repeat (4) step(1'b1, 1'b0, 8'hFF);

    step(1'b1, 1'b1, 8'hA5);
    repeat (FL + 1) step(1'b1, 1'b0, 8'h00);

    step(1'b1, 1'b1, 8'h01);
    repeat (FL + 1) step(1'b1, 1'b0, 8'h00);

    step(1'b1, 1'b1, 8'h0F);
    repeat (FL - 1) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hF0);
    repeat (FL + 1) step(1'b1, 1'b0, 8'h00);

    step(1'b1, 1'b1, 8'hC3);
    repeat (4) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h3C);
    repeat (FL) step(1'b1, 1'b0, 8'h00);

    step(1'b1, 1'b1, 8'h07);
    repeat (FL + 1) step(1'b1, 1'b0, 8'h00);

    step(1'b1, 1'b1, 8'hA7);
    repeat (4) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    repeat (3) step(1'b1, 1'b0, 8'h00);

    repeat (3000) begin
      r = ($urandom_range(0, 199) != 0);
      l = ($urandom_range(0, 3) == 0);
      d = W'($urandom);
      step(r, l, d);
    end

    repeat (FL + 2) step(1'b1, 1'b0, 8'h00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_y_tx.md
Name: serial_y_tx

Overview:
- Transmit side of the single-bit `y` serial line that feeds the team's `y`-driven state-machine circuits.
- Accepts a parallel word through a valid/ready handshake and serializes it onto `y`, one bit per CLK.
- Frame format: start bit, WIDTH data bits, optional parity bit, stop bit.
- Used as the stimulus source for the FSM blocks, replacing hand-written `y` toggling in benches.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..32).
- MSB_FIRST, 1, 1 = data[WIDTH-1] sent first; 0 = data[0] sent first.
- IDLE_LEVEL, 0, level of `y` while idle and during the stop bit. The start bit is ~IDLE_LEVEL.

Ports:
- CLK  input  1  clock; all state updates on posedge CLK.
- RST  input  1  synchronous reset, active-low; sampled on posedge CLK only.
- data_in  input  WIDTH  word to send; sampled only on an accepted load.
- load  input  1  request to send data_in.
- ready  output  1  high when a load will be accepted this cycle.
- y  output  1  serial line, registered.
- busy  output  1  high while a frame is in progress (START, DATA, PAR, STOP).
- done  output  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset: RST=0 at posedge CLK gives state=IDLE, y=IDLE_LEVEL, busy=0, done=0, shift register=0, bit counter=0.
- Reset mid-frame aborts the frame immediately. No partial stop bit is sent.
- States: IDLE, START, DATA, PAR (only with the optional feature), STOP.
- ready is combinational: ready = (state==IDLE) || (state==STOP).
- Accept: load && ready at a posedge.
  - data_in is captured into the shift register and the counter is set to WIDTH-1.
  - Next state is START.
  - load while ready=0 is ignored; data_in is not sampled.
- START: y=~IDLE_LEVEL for exactly 1 cycle, then DATA.
- DATA: y = current shift-register bit (MSB or LSB per MSB_FIRST); the register shifts each cycle.
  - Lasts exactly WIDTH cycles.
  - When the counter reaches 0, next state is PAR if enabled, else STOP.
- STOP: y=IDLE_LEVEL for 1 cycle and done=1.
  - If load is accepted in STOP, next state is START (back-to-back frames, no idle gap).
  - Otherwise next state is IDLE.
- Latency: the first data bit appears on `y` 2 cycles after the accepting edge.
- Frame length: WIDTH+2 cycles (WIDTH+3 with parity). Back-to-back throughput is one frame per frame length.
- Simultaneous RST=0 and load: reset wins and the load is dropped.
- The FSM never enters an undefined state encoding. The default branch returns to IDLE with y=IDLE_LEVEL.

Optional Feature:
- Macro: SERIAL_Y_TX_PARITY_EN.
- Defined:
  - PAR state is inserted after DATA for 1 cycle.
  - y = even parity, i.e. XOR of the captured data word, computed at capture and held in a register.
  - Frame length becomes WIDTH+3.
- Undefined:
  - PAR state, parity register and logic are absent.
  - DATA goes directly to STOP.

Decomposition:
- Shared package `serial_y_pkg`:
  - state encoding constants ST_IDLE=3'd0, ST_START=3'd1, ST_DATA=3'd2, ST_PAR=3'd3, ST_STOP=3'd4.
  - default WIDTH constant.
  - Both this block and a future matching receiver use it.
- One natural sub-module: `piso_shift_reg`.
  - Parallel-load/serial-out register with load, shift enable, MSB_FIRST direction and synchronous active-low RST.
  - The top module holds the FSM, bit counter, parity and handshake.

Test Plan:
- Reset: hold RST=0 for 3 cycles with load=1 and data_in=8'hFF -> y=0, ready=1, busy=0, done=0, and no frame starts after RST=1 until load is sampled again.
- Single frame, MSB_FIRST=1, data_in=8'hA5 -> y sequence from the cycle after accept: 1, 1,0,1,0,0,1,0,1, 0; done high on the stop cycle only; then IDLE.
- LSB_FIRST (MSB_FIRST=0), data_in=8'h01 -> y: 1, 1,0,0,0,0,0,0,0, 0.
- Back-to-back: load 8'h0F, then assert load with 8'hF0 during STOP -> the second start bit immediately follows the stop bit, with no IDLE cycle; total 20 cycles for both frames.
- Ignored load: pulse load with 8'h3C in the middle of DATA -> the current frame is unaffected, the 8'h3C frame is never sent, and ready stays 0 until STOP.
- With SERIAL_Y_TX_PARITY_EN, data_in=8'h07 -> after 8 data bits, PAR bit y=1 (odd count of ones), then stop; frame length 11 cycles. Also apply RST=0 mid-DATA -> y=0 and IDLE on the next edge.
